// File: rtl/hazard_forward_ctrl.sv
// Pipeline hazard, forwarding and branch-flush control for the Quinta RV32I core.
// A scoreboard of in-flight destination registers drives stall/bubble/kill and EX operand forwarding.
module hazard_forward_ctrl #(
    parameter int XLEN        = 32,
    parameter int NSLOTS      = 3,
    parameter int LOAD_READY  = 2,
    parameter int BRANCH_SLOT = 1
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       id_valid,
    input  logic [4:0]                 id_rs1,
    input  logic [4:0]                 id_rs2,
    input  logic                       id_rs1_used,
    input  logic                       id_rs2_used,
    input  logic [4:0]                 id_rd,
    input  logic                       id_reg_write,
    input  logic                       id_is_load,
    input  logic                       stall_ext,
    input  logic                       branch_taken,
    input  logic [(NSLOTS-1)*XLEN-1:0] result_data,
    output logic                       advance,
    output logic                       stall_decode,
    output logic                       bubble_ex,
    output logic                       flush_front,
    output logic [NSLOTS-1:0]          kill_mask,
    output logic [2:0]                 fwd1_sel,
    output logic [2:0]                 fwd2_sel,
    output logic [XLEN-1:0]            fwd1_data,
    output logic [XLEN-1:0]            fwd2_data
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       is_load;
    } prod_t;

    // Producer fields travel down every slot; source fields matter only in slot 0 (EX).
    prod_t      sb [NSLOTS];
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic       ex_rs1_used;
    logic       ex_rs2_used;
    logic       hazard;

    function automatic logic writes(prod_t e, logic [4:0] r);
        return e.valid && e.reg_write && (e.rd == r) && (r != 5'd0);
    endfunction

    function automatic int ready_slot(prod_t e);
        return e.is_load ? LOAD_READY : 1;
    endfunction

    always_comb begin
        hazard = 1'b0;
        for (int s = 0; s < NSLOTS; s++) begin
            if (id_valid && (s + 1 < ready_slot(sb[s])) &&
                ((id_rs1_used && writes(sb[s], id_rs1)) ||
                 (id_rs2_used && writes(sb[s], id_rs2))))
                hazard = 1'b1;
        end
    end

    // Youngest matching producer wins; if it is not yet ready the operand stays on the register file.
    always_comb begin
        logic found1;
        logic found2;
        found1    = 1'b0;
        found2    = 1'b0;
        fwd1_sel  = '0;
        fwd2_sel  = '0;
        fwd1_data = '0;
        fwd2_data = '0;
        for (int i = 1; i < NSLOTS; i++) begin
            if (!found1 && ex_rs1_used && writes(sb[i], ex_rs1)) begin
                found1 = 1'b1;
                if (i >= ready_slot(sb[i])) begin
                    fwd1_sel  = 3'(i);
                    fwd1_data = result_data[(i-1)*XLEN +: XLEN];
                end
            end
            if (!found2 && ex_rs2_used && writes(sb[i], ex_rs2)) begin
                found2 = 1'b1;
                if (i >= ready_slot(sb[i])) begin
                    fwd2_sel  = 3'(i);
                    fwd2_data = result_data[(i-1)*XLEN +: XLEN];
                end
            end
        end
        if (!start) begin
            fwd1_sel  = '0;
            fwd2_sel  = '0;
            fwd1_data = '0;
            fwd2_data = '0;
        end
    end

    always_comb begin
        advance      = 1'b0;
        stall_decode = 1'b0;
        bubble_ex    = 1'b0;
        flush_front  = 1'b0;
        kill_mask    = '0;
        if (start) begin
            if (branch_taken) begin
                advance     = 1'b1;
                flush_front = 1'b1;
                bubble_ex   = 1'b1;
                for (int i = 0; i < BRANCH_SLOT; i++) kill_mask[i] = 1'b1;
            end else if (stall_ext) begin
                stall_decode = 1'b1;
            end else if (hazard) begin
                advance      = 1'b1;
                stall_decode = 1'b1;
                bubble_ex    = 1'b1;
            end else begin
                advance = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            // NOTE: every scoreboard entry is cleared on reset; a stale valid bit would stall or forward.
            for (int i = 0; i < NSLOTS; i++) sb[i] <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rs1_used <= 1'b0;
            ex_rs2_used <= 1'b0;
        end else if (advance) begin
            for (int i = 1; i < NSLOTS; i++) sb[i] <= kill_mask[i-1] ? '0 : sb[i-1];
            if (branch_taken || hazard) begin
                sb[0]       <= '0;
                ex_rs1      <= '0;
                ex_rs2      <= '0;
                ex_rs1_used <= 1'b0;
                ex_rs2_used <= 1'b0;
            end else begin
                sb[0]       <= '{valid: id_valid, rd: id_rd, reg_write: id_reg_write, is_load: id_is_load};
                ex_rs1      <= id_rs1;
                ex_rs2      <= id_rs2;
                ex_rs1_used <= id_valid && id_rs1_used;
                ex_rs2_used <= id_valid && id_rs2_used;
            end
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench: two configurations (3/2/1 and 5/3/2) share stimulus and are compared
// every cycle against a queue-based reference model, plus directed load-use/branch/stall cases.
module tb_hazard_forward_ctrl;

    localparam int XLEN = 32;
    localparam int NA = 3, LA = 2, BA = 1;
    localparam int NB = 5, LB = 3, BB = 2;

    logic sys_clk = 1'b0;
    logic rst, start, id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_is_load;
    logic stall_ext, branch_taken;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [(NA-1)*XLEN-1:0] res_a;
    logic [(NB-1)*XLEN-1:0] res_b;

    logic adv_a, sd_a, bub_a, ff_a, adv_b, sd_b, bub_b, ff_b;
    logic [NA-1:0] km_a;
    logic [NB-1:0] km_b;
    logic [2:0] s1_a, s2_a, s1_b, s2_b;
    logic [XLEN-1:0] d1_a, d2_a, d1_b, d2_b;

    int total = 0, passed = 0, fails = 0, cyc = 0;
    int bubc_a, bubc_b;

    always #5 sys_clk = ~sys_clk;

    hazard_forward_ctrl #(.XLEN(XLEN), .NSLOTS(NA), .LOAD_READY(LA), .BRANCH_SLOT(BA)) dut_a (
        .sys_clk(sys_clk), .rst(rst), .start(start), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .stall_ext(stall_ext), .branch_taken(branch_taken), .result_data(res_a),
        .advance(adv_a), .stall_decode(sd_a), .bubble_ex(bub_a), .flush_front(ff_a),
        .kill_mask(km_a), .fwd1_sel(s1_a), .fwd2_sel(s2_a), .fwd1_data(d1_a), .fwd2_data(d2_a));

    hazard_forward_ctrl #(.XLEN(XLEN), .NSLOTS(NB), .LOAD_READY(LB), .BRANCH_SLOT(BB)) dut_b (
        .sys_clk(sys_clk), .rst(rst), .start(start), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .stall_ext(stall_ext), .branch_taken(branch_taken), .result_data(res_b),
        .advance(adv_b), .stall_decode(sd_b), .bubble_ex(bub_b), .flush_front(ff_b),
        .kill_mask(km_b), .fwd1_sel(s1_b), .fwd2_sel(s2_b), .fwd1_data(d1_b), .fwd2_data(d2_b));

    // Reference model: a queue of in-flight instructions, youngest at index 0.
    typedef struct {
        bit v; int rd; bit wr; bit ld; int rs1; int rs2; bit u1; bit u2;
    } ent_t;
    typedef ent_t ent_q_t[$];
    typedef struct {
        bit adv; bit sd; bit bub; bit ff; int km; int s1; int s2; bit haz;
    } exp_t;

    ent_q_t qa, qb;
    exp_t ea, eb;

    function automatic bit writes(ent_t e, int r);
        return e.v && e.wr && (e.rd == r) && (r != 0);
    endfunction

    function automatic int fwd_pick(ent_q_t q, int lr, int r, bit wanted);
        if (!wanted) return 0;
        for (int i = 1; i < q.size(); i++)
            if (writes(q[i], r)) return (i >= (q[i].ld ? lr : 1)) ? i : 0;
        return 0;
    endfunction

    function automatic exp_t predict(ent_q_t q, int lr, int bs);
        exp_t e = '{default: 0};
        for (int s = 0; s < q.size(); s++)
            if (id_valid && (s + 1 < (q[s].ld ? lr : 1)) &&
                ((id_rs1_used && writes(q[s], int'(id_rs1))) ||
                 (id_rs2_used && writes(q[s], int'(id_rs2)))))
                e.haz = 1;
        if (!start) return e;
        e.s1 = fwd_pick(q, lr, q[0].rs1, q[0].v && q[0].u1);
        e.s2 = fwd_pick(q, lr, q[0].rs2, q[0].v && q[0].u2);
        if (branch_taken) begin
            e.adv = 1; e.ff = 1; e.bub = 1; e.km = (1 << bs) - 1;
        end else if (stall_ext) begin
            e.sd = 1;
        end else if (e.haz) begin
            e.adv = 1; e.sd = 1; e.bub = 1;
        end else begin
            e.adv = 1;
        end
        return e;
    endfunction

    function automatic ent_q_t next_q(ent_q_t q, int bs, bit haz);
        ent_t blank = '{default: 0};
        ent_t fresh;
        int n = q.size();
        if (rst) begin
            q.delete();
            repeat (n) q.push_back(blank);
            return q;
        end
        if (!start) return q;
        if (branch_taken) begin
            for (int i = 0; i < bs; i++) q[i] = blank;
            void'(q.pop_back());
            q.push_front(blank);
            return q;
        end
        if (stall_ext) return q;
        void'(q.pop_back());
        if (haz) begin
            q.push_front(blank);
        end else begin
            fresh.v = id_valid; fresh.rd = int'(id_rd); fresh.wr = id_reg_write; fresh.ld = id_is_load;
            fresh.rs1 = int'(id_rs1); fresh.rs2 = int'(id_rs2);
            fresh.u1 = id_rs1_used; fresh.u2 = id_rs2_used;
            q.push_front(fresh);
        end
        return q;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic cmp(string t, exp_t e, logic adv, logic sd, logic bub, logic ff, logic [7:0] km,
                       logic [2:0] s1, logic [2:0] s2, logic [31:0] d1, logic [31:0] d2,
                       logic [127:0] res);
        check({t, ".advance"}, 32'(adv), 32'(e.adv));
        check({t, ".stall_decode"}, 32'(sd), 32'(e.sd));
        check({t, ".bubble_ex"}, 32'(bub), 32'(e.bub));
        check({t, ".flush_front"}, 32'(ff), 32'(e.ff));
        check({t, ".kill_mask"}, 32'(km), e.km);
        check({t, ".fwd1_sel"}, 32'(s1), e.s1);
        check({t, ".fwd2_sel"}, 32'(s2), e.s2);
        check({t, ".fwd1_data"}, d1, (e.s1 == 0) ? 32'h0 : res[(e.s1-1)*32 +: 32]);
        check({t, ".fwd2_data"}, d2, (e.s2 == 0) ? 32'h0 : res[(e.s2-1)*32 +: 32]);
    endtask

    task automatic eval();
        @(negedge sys_clk);
        ea = predict(qa, LA, BA);
        eb = predict(qb, LB, BB);
        cmp("a", ea, adv_a, sd_a, bub_a, ff_a, 8'(km_a), s1_a, s2_a, d1_a, d2_a, 128'(res_a));
        cmp("b", eb, adv_b, sd_b, bub_b, ff_b, 8'(km_b), s1_b, s2_b, d1_b, d2_b, 128'(res_b));
    endtask

    task automatic clock();
        qa = next_q(qa, BA, ea.haz);
        qb = next_q(qb, BB, eb.haz);
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        eval();
        clock();
    endtask

    task automatic set_id(bit v, int rd, bit wr, bit ld, int rs1, bit u1, int rs2, bit u2);
        id_valid = v; id_rd = 5'(rd); id_reg_write = wr; id_is_load = ld;
        id_rs1 = 5'(rs1); id_rs1_used = u1; id_rs2 = 5'(rs2); id_rs2_used = u2;
    endtask

    task automatic flush();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (NB + 1) step();
    endtask

    initial begin
        ent_t blank = '{default: 0};
        rst = 1; start = 1; stall_ext = 0; branch_taken = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        res_a = {32'hDEADBEEF, 32'h00000007};
        res_b = {32'h44444444, 32'h33333333, 32'hDEADBEEF, 32'h00000007};
        repeat (2) @(posedge sys_clk);
        #1;
        repeat (NA) qa.push_back(blank);
        repeat (NB) qb.push_back(blank);
        rst = 0;

        // Reset state: only advance is high.
        eval();
        check("reset_advance", 32'(adv_a), 32'd1);
        check("reset_stall", 32'(sd_a), 32'd0);
        clock();

        // Load-use: lw x5 then add x6,x5,x1.
        flush();
        set_id(1, 5, 1, 1, 2, 1, 0, 0);
        step();
        set_id(1, 6, 1, 0, 5, 1, 1, 1);
        bubc_a = 0; bubc_b = 0;
        repeat (2) begin
            eval(); bubc_a += int'(sd_a); bubc_b += int'(sd_b); clock();
        end
        eval();
        check("lu_fwd1_sel", 32'(s1_a), 32'd2);
        check("lu_fwd1_data", d1_a, 32'hDEADBEEF);
        bubc_b += int'(sd_b);
        clock();
        check("lu_bubbles_a", bubc_a, 32'd1);
        check("lu_bubbles_b", bubc_b, 32'd2);

        // Back-to-back ALU: addi x3 then add x4,x3,x3.
        flush();
        set_id(1, 3, 1, 0, 0, 1, 0, 0);
        step();
        set_id(1, 4, 1, 0, 3, 1, 3, 1);
        eval();
        check("alu_no_stall", 32'(sd_a), 32'd0);
        clock();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        eval();
        check("alu_fwd1_sel", 32'(s1_a), 32'd1);
        check("alu_fwd2_sel", 32'(s2_a), 32'd1);
        check("alu_fwd2_data", d2_a, 32'h00000007);
        clock();

        // Youngest wins: x7 written twice.
        flush();
        set_id(1, 7, 1, 0, 0, 0, 0, 0); step();
        set_id(1, 7, 1, 0, 0, 0, 0, 0); step();
        set_id(1, 8, 1, 0, 7, 1, 0, 0); step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        eval();
        check("youngest_sel", 32'(s1_a), 32'd1);
        clock();

        // x0 in flight (even as a load) never stalls nor forwards.
        flush();
        set_id(1, 0, 1, 1, 0, 0, 0, 0); step();
        set_id(1, 9, 1, 0, 0, 1, 0, 1);
        eval();
        check("x0_no_stall", 32'(sd_a), 32'd0);
        clock();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        eval();
        check("x0_sel", 32'(s1_a), 32'd0);
        clock();

        // Branch with two valid younger entries.
        flush();
        set_id(1, 9, 1, 0, 0, 0, 0, 0); step();
        set_id(1, 10, 1, 0, 0, 0, 0, 0); step();
        set_id(1, 11, 1, 0, 0, 0, 0, 0);
        branch_taken = 1;
        eval();
        check("br_kill_a", 32'(km_a), 32'b001);
        check("br_kill_b", 32'(km_b), 32'b00011);
        check("br_flush", 32'(ff_a), 32'd1);
        check("br_bubble", 32'(bub_a), 32'd1);
        clock();
        branch_taken = 0;
        set_id(1, 12, 1, 0, 10, 1, 0, 0); step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        eval();
        check("br_killed_a", 32'(s1_a), 32'd0);
        check("br_killed_b", 32'(s1_b), 32'd0);
        clock();

        // stall_ext held 3 cycles during a load-use.
        flush();
        set_id(1, 5, 1, 1, 0, 0, 0, 0); step();
        set_id(1, 6, 1, 0, 5, 1, 0, 0);
        stall_ext = 1;
        repeat (3) begin
            eval();
            check("ext_advance", 32'(adv_a), 32'd0);
            check("ext_stall", 32'(sd_a), 32'd1);
            clock();
        end
        stall_ext = 0;
        eval();
        check("ext_then_bubble", 32'(bub_a), 32'd1);
        clock();

        // start = 0 freezes state and silences controls.
        flush();
        set_id(1, 5, 1, 1, 0, 0, 0, 0); step();
        set_id(1, 6, 1, 0, 5, 1, 0, 0);
        start = 0;
        repeat (2) begin
            eval();
            check("nostart_advance", 32'(adv_a), 32'd0);
            check("nostart_stall", 32'(sd_a), 32'd0);
            clock();
        end
        start = 1;
        eval();
        check("restart_bubble", 32'(bub_a), 32'd1);
        clock();

        // rst in the middle of a hazard.
        flush();
        set_id(1, 5, 1, 1, 0, 0, 0, 0); step();
        set_id(1, 6, 1, 0, 5, 1, 0, 0);
        eval();
        check("pre_rst_stall", 32'(sd_a), 32'd1);
        rst = 1;
        clock();
        rst = 0;
        eval();
        check("post_rst_stall_a", 32'(sd_a), 32'd0);
        check("post_rst_stall_b", 32'(sd_b), 32'd0);
        check("post_rst_advance", 32'(adv_a), 32'd1);
        clock();

        // Randomized traffic on a small register set to force collisions.
        for (int n = 0; n < 400; n++) begin
            set_id($urandom_range(99) < 80, $urandom_range(3), $urandom_range(1), $urandom_range(2) == 0,
                   $urandom_range(3), $urandom_range(1), $urandom_range(3), $urandom_range(1));
            branch_taken = ($urandom_range(99) < 8);
            stall_ext    = ($urandom_range(99) < 10);
            start        = ($urandom_range(99) < 95);
            rst          = ($urandom_range(99) < 2);
            res_a = {$urandom, $urandom};
            res_b = {$urandom, $urandom, $urandom, $urandom};
            step();
        end

        if (fails != 0) $display("%0d comparisons disagreed", fails);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
